// File: rtl/rgb888_to_gray.sv
// RGB888 -> luma Y=(77R+150G+29B)>>8 with hsync/vsync delayed to match; fixed 3-cycle latency, no backpressure.
// Also measures each armed frame against IW x IH and reports via frame_done/geom_err.
module rgb888_to_gray #(
   parameter int IW     = 640,
   parameter int IH     = 480,
   parameter int SRC_DW = 24,
   parameter int DST_DW = 8
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              src_rgb_hsync,
   input  logic              src_rgb_vsync,
   input  logic [SRC_DW-1:0] src_rgb_data,
   output logic              dst_gray_hsync,
   output logic              dst_gray_vsync,
   output logic [DST_DW-1:0] dst_gray_data,
   output logic              frame_done,
   output logic              geom_err
);
   logic [14:0]       r_prod_q, r_prod_d;
   logic [15:0]       g_prod_q, g_prod_d;
   logic [12:0]       b_prod_q, b_prod_d;
   logic [15:0]       sum_q, sum_d;
   logic [DST_DW-1:0] gray_q, gray_d;
   logic [2:0]        hs_sr_q, vs_sr_q;

   logic        hs_prev_q, vs_prev_q, vs_low_seen_q, armed_q;
   logic [15:0] col_cnt_q, col_cnt_d, col_base;
   logic [15:0] line_cnt_q, line_cnt_d;
   logic        line_err_q, line_err_d;
   logic [1:0]  fall_sr_q, bad_sr_q;
   logic        frame_done_q, geom_err_q;
   logic        hs_fall, vs_fall, vs_rise, line_end, armed_fall, frame_bad;
   logic        unused_sum_lsb;

   assign r_prod_d = 15'(src_rgb_data[23:16]) * 15'd77;
   assign g_prod_d = 16'(src_rgb_data[15:8])  * 16'd150;
   assign b_prod_d = 13'(src_rgb_data[7:0])   * 13'd29;
   assign sum_d    = 16'(r_prod_q) + g_prod_q + 16'(b_prod_q);
   // hs_sr_q[1] is the sync bit that travels alongside sum_q into the last stage
   assign gray_d   = hs_sr_q[1] ? sum_q[15 -: DST_DW] : '0;
   assign unused_sum_lsb = ^sum_q[15-DST_DW:0];

   always_comb begin
      hs_fall    = hs_prev_q & ~src_rgb_hsync;
      vs_fall    = vs_prev_q & ~src_rgb_vsync;
      // a frame already open at reset release has no observed low, so it is never armed
      vs_rise    = src_rgb_vsync & ~vs_prev_q & vs_low_seen_q;
      line_end   = hs_fall | (vs_fall & hs_prev_q);
      col_base   = line_end ? 16'd0 : col_cnt_q;
      col_cnt_d  = col_base;
      line_cnt_d = line_cnt_q;
      line_err_d = line_err_q;
      if (src_rgb_hsync && col_base != 16'hFFFF)
         col_cnt_d = col_base + 16'd1;
      if (line_end && armed_q) begin
         if (line_cnt_q != 16'hFFFF)
            line_cnt_d = line_cnt_q + 16'd1;
         if (col_cnt_q != 16'(IW))
            line_err_d = 1'b1;
      end
      if (vs_rise) begin
         line_cnt_d = '0;
         line_err_d = 1'b0;
         col_cnt_d  = {15'd0, src_rgb_hsync};
      end
      armed_fall = vs_fall & armed_q;
      frame_bad  = line_err_d | (line_cnt_d != 16'(IH));
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod_q      <= '0;
         g_prod_q      <= '0;
         b_prod_q      <= '0;
         sum_q         <= '0;
         gray_q        <= '0;
         hs_sr_q       <= '0;
         vs_sr_q       <= '0;
         hs_prev_q     <= 1'b0;
         vs_prev_q     <= 1'b0;
         vs_low_seen_q <= 1'b0;
         armed_q       <= 1'b0;
         col_cnt_q     <= '0;
         line_cnt_q    <= '0;
         line_err_q    <= 1'b0;
         fall_sr_q     <= '0;
         bad_sr_q      <= '0;
         frame_done_q  <= 1'b0;
         geom_err_q    <= 1'b0;
      end else begin
         r_prod_q      <= r_prod_d;
         g_prod_q      <= g_prod_d;
         b_prod_q      <= b_prod_d;
         sum_q         <= sum_d;
         gray_q        <= gray_d;
         hs_sr_q       <= {hs_sr_q[1:0], src_rgb_hsync};
         vs_sr_q       <= {vs_sr_q[1:0], src_rgb_vsync};
         hs_prev_q     <= src_rgb_hsync;
         vs_prev_q     <= src_rgb_vsync;
         vs_low_seen_q <= vs_low_seen_q | ~src_rgb_vsync;
         armed_q       <= armed_q | vs_rise;
         col_cnt_q     <= col_cnt_d;
         line_cnt_q    <= line_cnt_d;
         line_err_q    <= line_err_d;
         // verdict rides with the vsync delay line so it lands as dst vsync falls
         fall_sr_q     <= {fall_sr_q[0], armed_fall};
         bad_sr_q      <= {bad_sr_q[0], frame_bad};
         frame_done_q  <= fall_sr_q[1];
         if (fall_sr_q[1])
            geom_err_q <= bad_sr_q[1];
      end
   end

   assign dst_gray_hsync = hs_sr_q[2];
   assign dst_gray_vsync = vs_sr_q[2];
   assign dst_gray_data  = gray_q;
   assign frame_done     = frame_done_q;
   assign geom_err       = geom_err_q;
endmodule

// File: tb/tb_rgb888_to_gray.sv
// Bench for rgb888_to_gray on a reduced 16x12 geometry: directed pixels, frame geometry cases,
// and a cycle-by-cycle delay-line check of sync, gray data and frame_done.
module tb_rgb888_to_gray;
   localparam int IW = 16;
   localparam int IH = 12;

   logic        pclk;
   logic        rst_n;
   logic        src_rgb_hsync;
   logic        src_rgb_vsync;
   logic [23:0] src_rgb_data;
   logic        dst_gray_hsync;
   logic        dst_gray_vsync;
   logic [7:0]  dst_gray_data;
   logic        frame_done;
   logic        geom_err;

   int   n_vec  = 0;
   int   n_err  = 0;
   int   fd_cnt = 0;
   logic mon_en = 1'b0;
   logic fd_arm = 1'b1;

   logic [3:0]  hs_h;
   logic [3:0]  vs_h;
   logic [23:0] d_h [4];

   logic [23:0] px     [5] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000};
   logic [7:0]  px_exp [5] = '{8'd255, 8'd76, 8'd149, 8'd28, 8'd0};

   rgb888_to_gray #(.IW(IW), .IH(IH), .SRC_DW(24), .DST_DW(8)) dut (
      .pclk           (pclk),
      .rst_n          (rst_n),
      .src_rgb_hsync  (src_rgb_hsync),
      .src_rgb_vsync  (src_rgb_vsync),
      .src_rgb_data   (src_rgb_data),
      .dst_gray_hsync (dst_gray_hsync),
      .dst_gray_vsync (dst_gray_vsync),
      .dst_gray_data  (dst_gray_data),
      .frame_done     (frame_done),
      .geom_err       (geom_err)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] gray_ref(input logic [23:0] d);
      int y;
      y = 77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0]);
      return 8'(y >> 8);
   endfunction

   task automatic drive(input logic hs, input logic vs, input logic [23:0] d);
      @(posedge pclk);
      #1;
      src_rgb_hsync = hs;
      src_rgb_vsync = vs;
      src_rgb_data  = d;
   endtask

   // Output at a given edge must equal the input sampled two edges earlier (3-cycle delay).
   initial begin
      hs_h = '0;
      vs_h = '0;
      foreach (d_h[i]) d_h[i] = '0;
      forever begin
         @(posedge pclk);
         if (!rst_n) begin
            hs_h = '0;
            vs_h = '0;
            foreach (d_h[i]) d_h[i] = '0;
         end else begin
            hs_h = {hs_h[2:0], src_rgb_hsync};
            vs_h = {vs_h[2:0], src_rgb_vsync};
            for (int i = 3; i > 0; i--) d_h[i] = d_h[i-1];
            d_h[0] = src_rgb_data;
            #1;
            if (mon_en) begin
               chk("sync_hs", {31'd0, dst_gray_hsync}, {31'd0, hs_h[2]});
               chk("sync_vs", {31'd0, dst_gray_vsync}, {31'd0, vs_h[2]});
               chk("gray", {24'd0, dst_gray_data}, hs_h[2] ? {24'd0, gray_ref(d_h[2])} : 32'd0);
               chk("fdone_time", {31'd0, frame_done}, {31'd0, vs_h[3] & ~vs_h[2] & fd_arm});
            end
            if (frame_done) fd_cnt++;
         end
      end
   end

   task automatic send_frame(input int lines, input int short_line, input bit start_hot,
                             input bit merge_end);
      if (!start_hot) begin
         drive(1'b0, 1'b1, 24'd0);
         drive(1'b0, 1'b1, 24'd0);
      end
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ((l == short_line) ? IW - 1 : IW); p++)
            drive(1'b1, 1'b1, 24'($urandom));
         if (!(merge_end && l == lines - 1))
            repeat (4) drive(1'b0, 1'b1, 24'd0);
      end
      repeat (8) drive(1'b0, 1'b0, 24'd0);
   endtask

   task automatic frame_test(input string tag, input int lines, input int short_line,
                             input bit start_hot, input bit merge_end, input logic exp_err);
      int c0;
      c0 = fd_cnt;
      send_frame(lines, short_line, start_hot, merge_end);
      chk({tag, "_done"}, 32'(fd_cnt - c0), 32'd1);
      chk({tag, "_geom"}, {31'd0, geom_err}, {31'd0, exp_err});
   endtask

   initial begin
      int c0;
      rst_n         = 1'b0;
      src_rgb_hsync = 1'b0;
      src_rgb_vsync = 1'b0;
      src_rgb_data  = '0;
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_hs", {31'd0, dst_gray_hsync}, 32'd0);
      chk("rst_vs", {31'd0, dst_gray_vsync}, 32'd0);
      chk("rst_data", {24'd0, dst_gray_data}, 32'd0);
      chk("rst_fdone", {31'd0, frame_done}, 32'd0);
      chk("rst_geom", {31'd0, geom_err}, 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, px[i]);
         drive(1'b0, 1'b0, 24'd0);
         drive(1'b0, 1'b0, 24'd0);
         chk("px_early_hs", {31'd0, dst_gray_hsync}, 32'd0);
         drive(1'b0, 1'b0, 24'd0);
         chk("px_gray", {24'd0, dst_gray_data}, {24'd0, px_exp[i]});
         chk("px_hs", {31'd0, dst_gray_hsync}, 32'd1);
         drive(1'b0, 1'b0, 24'd0);
         chk("px_late_hs", {31'd0, dst_gray_hsync}, 32'd0);
         chk("px_late_data", {24'd0, dst_gray_data}, 32'd0);
      end

      frame_test("good1", IH, -1, 1'b0, 1'b0, 1'b0);
      frame_test("good2", IH, -1, 1'b0, 1'b0, 1'b0);
      frame_test("short_line", IH, 5, 1'b0, 1'b0, 1'b1);
      frame_test("recover", IH, -1, 1'b0, 1'b0, 1'b0);
      frame_test("lines_low", IH - 1, -1, 1'b0, 1'b0, 1'b1);
      frame_test("lines_high", IH + 1, -1, 1'b0, 1'b0, 1'b1);

      // reset mid-line of an armed frame while geom_err is still 1
      drive(1'b0, 1'b1, 24'd0);
      for (int l = 0; l < 3; l++) begin
         repeat (IW) drive(1'b1, 1'b1, 24'($urandom));
         repeat (4) drive(1'b0, 1'b1, 24'd0);
      end
      repeat (8) drive(1'b1, 1'b1, 24'($urandom));
      @(posedge pclk);
      #1;
      rst_n  = 1'b0;
      mon_en = 1'b0;
      fd_arm = 1'b0;
      #1;
      chk("inrst_out", {20'd0, dst_gray_hsync, dst_gray_vsync, dst_gray_data, frame_done, geom_err}, 32'd0);
      repeat (4) begin
         drive(1'b1, 1'b1, 24'($urandom));
         chk("inrst_out", {20'd0, dst_gray_hsync, dst_gray_vsync, dst_gray_data, frame_done, geom_err}, 32'd0);
      end
      @(posedge pclk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      c0     = fd_cnt;
      repeat (4) drive(1'b1, 1'b1, 24'($urandom));
      repeat (4) drive(1'b0, 1'b1, 24'd0);
      for (int l = 0; l < 5; l++) begin
         repeat (IW) drive(1'b1, 1'b1, 24'($urandom));
         repeat (4) drive(1'b0, 1'b1, 24'd0);
      end
      repeat (8) drive(1'b0, 1'b0, 24'd0);
      chk("partial_no_done", 32'(fd_cnt - c0), 32'd0);
      chk("partial_geom", {31'd0, geom_err}, 32'd0);
      fd_arm = 1'b1;
      frame_test("post_rst", IH, -1, 1'b0, 1'b0, 1'b0);

      frame_test("zero_len", 0, -1, 1'b0, 1'b0, 1'b1);
      frame_test("merge_end", IH, -1, 1'b0, 1'b1, 1'b0);
      frame_test("hot_start", IH, -1, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
